// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake plus operand and result bus
// for the bit-serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out, ovf
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder. One operand bit pair is consumed
// per clock through a single full-adder slice and one carry flip-flop.
// The result registers are updated only when an operation completes.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  // Holds the WIDTH-1 sum bits produced so far, newest at the MSB; the
  // final bit is appended combinationally so the sum register can load on
  // the same edge that performs the last step.
  logic [WIDTH-2:0] r_ss;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_carry;
  logic [WIDTH-1:0] w_full;

  // Next-state logic and the single full-adder slice
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_s      = r_sa[0] ^ r_sb[0] ^ r_carry;
    w_carry  = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);
    w_last   = (r_cnt == LAST);
    w_full   = {w_s, r_ss};
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Operand load, bit stepping and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_ss    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_sa    <= bus.a;
      r_sb    <= bus.b;
      r_carry <= bus.c_in;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_sa    <= r_sa >> 1;
      r_sb    <= r_sb >> 1;
      r_ss    <= w_full[WIDTH-1:1];
      r_carry <= w_carry;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        // r_carry here is the carry into the MSB, w_carry the carry out.
        r_sum  <= w_full;
        r_cout <= w_carry;
        r_ovf  <= r_carry ^ w_carry;
      end
    end
  end

  assign bus.busy  = (r_state == RUN);
  assign bus.done  = (r_state == DONE);
  assign bus.sum   = r_sum;
  assign bus.c_out = r_cout;
  assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed handshake scenarios plus randomized regression
// at WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_serial_adder;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  serial_adder_if #(.WIDTH(8))  bus8 ();
  serial_adder_if #(.WIDTH(16)) bus16 ();

  serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer addition; returns {ovf, c_out, sum[31:0]}.
  function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic ci);
    longint unsigned full;
    longint unsigned mask;
    logic [31:0] s;
    logic co, sa, sb, ss, ov;
    mask = (64'd1 << w) - 64'd1;
    full = longint'(a & mask[31:0]) + longint'(b & mask[31:0]) + longint'(ci);
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    sa   = a[w-1];
    sb   = b[w-1];
    ss   = s[w-1];
    ov   = (sa == sb) && (ss != sa);
    return {ov, co, s};
  endfunction

  task automatic do_op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [33:0] e;
    int lat, bcnt;
    logic [7:0] s;
    logic co, ov, bz;
    e = model(8, {24'd0, a}, {24'd0, b}, ci);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.c_in = ci;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 0; bcnt = 0; s = '0; co = 0; ov = 0; bz = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus8.done) begin
        lat = n; s = bus8.sum; co = bus8.c_out; ov = bus8.ovf; bz = bus8.busy;
        break;
      end
      if (bus8.busy) bcnt++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check({tag, "_lat"}, 64'(lat), 64'd9);
    check({tag, "_busycyc"}, 64'(bcnt), 64'd8);
    check({tag, "_busy_at_done"}, 64'(bz), 64'd0);
    check({tag, "_sum"}, 64'(s), 64'(e[7:0]));
    check({tag, "_cout"}, 64'(co), 64'(e[32]));
    check({tag, "_ovf"}, 64'(ov), 64'(e[33]));
  endtask

  task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic ci);
    logic [33:0] e;
    int lat;
    logic [15:0] s;
    logic co, ov;
    e = model(16, {16'd0, a}, {16'd0, b}, ci);
    bus16.start = 1'b1; bus16.a = a; bus16.b = b; bus16.c_in = ci;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    lat = 0; s = '0; co = 0; ov = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (bus16.done) begin
        lat = n; s = bus16.sum; co = bus16.c_out; ov = bus16.ovf;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("r16_lat", 64'(lat), 64'd17);
    check("r16_res", {46'd0, ov, co, s}, {46'd0, e[33], e[32], e[15:0]});
  endtask

  initial begin
    logic [33:0] e;
    int dcnt, d1, d2;
    logic [7:0] cs;
    logic cc, co;

    errors = 0; checks = 0;
    rst = 1'b1;
    bus8.start = 0;  bus8.a = '0;  bus8.b = '0;  bus8.c_in = 0;
    bus16.start = 0; bus16.a = '0; bus16.b = '0; bus16.c_in = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", 64'(bus8.busy), 64'd0);
    check("rst_done", 64'(bus8.done), 64'd0);
    check("rst_res", {61'd0, bus8.ovf, bus8.c_out, bus8.sum == 8'd0}, 64'd1);
    check("rst_busy16", 64'(bus16.busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_op8("t3c5a", 8'h3C, 8'h5A, 1'b0);
    do_op8("tff01", 8'hFF, 8'h01, 1'b0);
    do_op8("t7f00", 8'h7F, 8'h00, 1'b1);

    // Starts during RUN must be ignored
    e = model(8, 32'h0000_00A7, 32'h0000_0036, 1'b1);
    bus8.start = 1'b1; bus8.a = 8'hA7; bus8.b = 8'h36; bus8.c_in = 1'b1;
    @(posedge clk); #1;
    dcnt = 0; d1 = 0; cs = '0; cc = 0; co = 0;
    for (int n = 1; n <= 20; n++) begin
      bus8.start = (n == 3 || n == 5);
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.c_in = 1'($urandom);
      @(negedge clk);
      if (bus8.done) begin
        dcnt++; d1 = n; cs = bus8.sum; cc = bus8.c_out; co = bus8.ovf;
      end
      @(posedge clk); #1;
    end
    bus8.start = 1'b0;
    check("ign_donecnt", 64'(dcnt), 64'd1);
    check("ign_lat", 64'(d1), 64'd9);
    check("ign_res", {46'd0, co, cc, 8'd0, cs}, {46'd0, e[33], e[32], 8'd0, e[7:0]});

    // Back-to-back with start held high
    bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h02; bus8.c_in = 1'b0;
    @(posedge clk); #1;
    bus8.a = 8'h10; bus8.b = 8'h20;
    d1 = 0; d2 = 0; dcnt = 0;
    for (int n = 1; n <= 25; n++) begin
      if (n == 10) bus8.start = 1'b0;
      @(negedge clk);
      if (bus8.done) begin
        dcnt++;
        if (dcnt == 1) d1 = n;
        else d2 = n;
        if (dcnt == 2) check("b2b_sum2", 64'(bus8.sum), 64'h30);
      end
      if (n >= 9 && n <= 17) check("b2b_hold", 64'(bus8.sum), 64'h03);
      @(posedge clk); #1;
    end
    check("b2b_d1", 64'(d1), 64'd9);
    check("b2b_d2", 64'(d2), 64'd18);
    check("b2b_cnt", 64'(dcnt), 64'd2);

    // Reset in the middle of RUN
    bus8.start = 1'b1; bus8.a = 8'h3C; bus8.b = 8'h5A; bus8.c_in = 1'b0;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    dcnt = 0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 4) rst = 1'b1;
      if (n == 5) rst = 1'b0;
      @(negedge clk);
      if (n == 5) begin
        check("mrst_busy", 64'(bus8.busy), 64'd0);
        check("mrst_done", 64'(bus8.done), 64'd0);
        check("mrst_sum", 64'(bus8.sum), 64'd0);
        check("mrst_flags", {62'd0, bus8.c_out, bus8.ovf}, 64'd0);
      end
      if (bus8.done) dcnt++;
      @(posedge clk); #1;
    end
    check("mrst_nodone", 64'(dcnt), 64'd0);
    do_op8("after_rst", 8'hC3, 8'h81, 1'b1);

    // rst and start on the same edge: start is not accepted
    rst = 1'b1; bus8.start = 1'b1; bus8.a = 8'h55; bus8.b = 8'h66;
    @(posedge clk); #1;
    rst = 1'b0; bus8.start = 1'b0;
    dcnt = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 1) check("rs_busy", 64'(bus8.busy), 64'd0);
      if (bus8.done || bus8.busy) dcnt++;
      @(posedge clk); #1;
    end
    check("rs_noop", 64'(dcnt), 64'd0);

    // Randomized regression
    for (int i = 0; i < 1000; i++)
      do_op8("r8", 8'($urandom), 8'($urandom), 1'($urandom));
    do_op16(16'h7FFF, 16'h0000, 1'b1);
    do_op16(16'hFFFF, 16'hFFFF, 1'b1);
    for (int i = 0; i < 1000; i++)
      do_op16(16'($urandom), 16'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1);
  end

endmodule
